// File: rtl/trig_lut_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trig_lut_unit
// Description : Fixed-latency integer-degree sine/cosine evaluator returning a
//               signed 16.16 result from a quarter-wave lookup table.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_lut_unit #(
    parameter int IS_COSINE = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [8:0]  value,
    output logic [31:0] amp_out,
    output logic        done
);

    localparam logic [8:0] c_deg_90  = 9'd90;
    localparam logic [8:0] c_deg_180 = 9'd180;
    localparam logic [8:0] c_deg_270 = 9'd270;
    localparam logic [8:0] c_deg_360 = 9'd360;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_FOLD   = 3'd2,
        S_LOOKUP = 3'd3,
        S_FINISH = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    logic [8:0]  r_angle;
    logic [6:0]  r_index;
    logic [1:0]  r_quad;
    logic        r_rom_wait;
    logic [16:0] r_rom_data;
    logic [16:0] r_rom_q;

    logic [8:0]  w_wrap;
    logic [8:0]  w_shift;
    logic [8:0]  w_reduced;
    logic [6:0]  w_index;
    logic [1:0]  w_quad;
    logic [31:0] w_mag;

    // Quarter-wave table: round(sin(i deg) * 65536), i = 0..90
    function automatic logic [16:0] rom_lookup(input logic [6:0] idx);
        case (idx)
            7'd0:  rom_lookup = 17'd0;     7'd1:  rom_lookup = 17'd1144;  7'd2:  rom_lookup = 17'd2287;
            7'd3:  rom_lookup = 17'd3430;  7'd4:  rom_lookup = 17'd4572;  7'd5:  rom_lookup = 17'd5712;
            7'd6:  rom_lookup = 17'd6850;  7'd7:  rom_lookup = 17'd7987;  7'd8:  rom_lookup = 17'd9121;
            7'd9:  rom_lookup = 17'd10252; 7'd10: rom_lookup = 17'd11380; 7'd11: rom_lookup = 17'd12505;
            7'd12: rom_lookup = 17'd13626; 7'd13: rom_lookup = 17'd14742; 7'd14: rom_lookup = 17'd15855;
            7'd15: rom_lookup = 17'd16962; 7'd16: rom_lookup = 17'd18064; 7'd17: rom_lookup = 17'd19161;
            7'd18: rom_lookup = 17'd20252; 7'd19: rom_lookup = 17'd21336; 7'd20: rom_lookup = 17'd22415;
            7'd21: rom_lookup = 17'd23486; 7'd22: rom_lookup = 17'd24550; 7'd23: rom_lookup = 17'd25607;
            7'd24: rom_lookup = 17'd26656; 7'd25: rom_lookup = 17'd27697; 7'd26: rom_lookup = 17'd28729;
            7'd27: rom_lookup = 17'd29753; 7'd28: rom_lookup = 17'd30767; 7'd29: rom_lookup = 17'd31772;
            7'd30: rom_lookup = 17'd32768; 7'd31: rom_lookup = 17'd33754; 7'd32: rom_lookup = 17'd34729;
            7'd33: rom_lookup = 17'd35693; 7'd34: rom_lookup = 17'd36647; 7'd35: rom_lookup = 17'd37590;
            7'd36: rom_lookup = 17'd38521; 7'd37: rom_lookup = 17'd39441; 7'd38: rom_lookup = 17'd40348;
            7'd39: rom_lookup = 17'd41243; 7'd40: rom_lookup = 17'd42126; 7'd41: rom_lookup = 17'd42995;
            7'd42: rom_lookup = 17'd43852; 7'd43: rom_lookup = 17'd44695; 7'd44: rom_lookup = 17'd45525;
            7'd45: rom_lookup = 17'd46341; 7'd46: rom_lookup = 17'd47143; 7'd47: rom_lookup = 17'd47930;
            7'd48: rom_lookup = 17'd48703; 7'd49: rom_lookup = 17'd49461; 7'd50: rom_lookup = 17'd50203;
            7'd51: rom_lookup = 17'd50931; 7'd52: rom_lookup = 17'd51643; 7'd53: rom_lookup = 17'd52339;
            7'd54: rom_lookup = 17'd53020; 7'd55: rom_lookup = 17'd53684; 7'd56: rom_lookup = 17'd54332;
            7'd57: rom_lookup = 17'd54963; 7'd58: rom_lookup = 17'd55578; 7'd59: rom_lookup = 17'd56175;
            7'd60: rom_lookup = 17'd56756; 7'd61: rom_lookup = 17'd57319; 7'd62: rom_lookup = 17'd57865;
            7'd63: rom_lookup = 17'd58393; 7'd64: rom_lookup = 17'd58903; 7'd65: rom_lookup = 17'd59396;
            7'd66: rom_lookup = 17'd59870; 7'd67: rom_lookup = 17'd60326; 7'd68: rom_lookup = 17'd60764;
            7'd69: rom_lookup = 17'd61183; 7'd70: rom_lookup = 17'd61584; 7'd71: rom_lookup = 17'd61966;
            7'd72: rom_lookup = 17'd62328; 7'd73: rom_lookup = 17'd62672; 7'd74: rom_lookup = 17'd62997;
            7'd75: rom_lookup = 17'd63303; 7'd76: rom_lookup = 17'd63589; 7'd77: rom_lookup = 17'd63856;
            7'd78: rom_lookup = 17'd64104; 7'd79: rom_lookup = 17'd64332; 7'd80: rom_lookup = 17'd64540;
            7'd81: rom_lookup = 17'd64729; 7'd82: rom_lookup = 17'd64898; 7'd83: rom_lookup = 17'd65048;
            7'd84: rom_lookup = 17'd65177; 7'd85: rom_lookup = 17'd65287; 7'd86: rom_lookup = 17'd65376;
            7'd87: rom_lookup = 17'd65446; 7'd88: rom_lookup = 17'd65496; 7'd89: rom_lookup = 17'd65526;
            7'd90: rom_lookup = 17'd65536;
            default: rom_lookup = 17'd0;
        endcase
    endfunction

    // cos x = sin(x + 90); a 9-bit angle needs at most one 360 subtraction
    always_comb begin
        w_wrap    = (r_angle >= c_deg_360) ? (r_angle - c_deg_360) : r_angle;
        w_shift   = w_wrap + c_deg_90;
        w_reduced = w_wrap;
        if (IS_COSINE != 0) begin
            w_reduced = (w_shift >= c_deg_360) ? (w_shift - c_deg_360) : w_shift;
        end
    end

    always_comb begin
        w_index = r_angle[6:0];
        w_quad  = 2'd0;
        if (r_angle <= c_deg_90) begin
            w_index = r_angle[6:0];
            w_quad  = 2'd0;
        end else if (r_angle <= c_deg_180) begin
            w_index = 7'(c_deg_180 - r_angle);
            w_quad  = 2'd1;
        end else if (r_angle <= c_deg_270) begin
            w_index = 7'(r_angle - c_deg_180);
            w_quad  = 2'd2;
        end else begin
            w_index = 7'(c_deg_360 - r_angle);
            w_quad  = 2'd3;
        end
    end

    assign w_mag = {15'd0, r_rom_q};

    // Two-stage ROM read (address-registered table plus output register)
    always_ff @(posedge clk_in) begin
        r_rom_data <= rom_lookup(r_index);
        r_rom_q    <= r_rom_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_angle    <= 9'd0;
            r_index    <= 7'd0;
            r_quad     <= 2'd0;
            r_rom_wait <= 1'b0;
            amp_out    <= 32'd0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_angle <= value;
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    r_angle <= w_reduced;
                    r_state <= S_FOLD;
                end
                S_FOLD: begin
                    r_index    <= w_index;
                    r_quad     <= w_quad;
                    r_rom_wait <= 1'b0;
                    r_state    <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    r_rom_wait <= 1'b1;
                    if (r_rom_wait) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // Negating a zero magnitude yields zero, so no -0 appears
                    amp_out <= r_quad[1] ? (32'd0 - w_mag) : w_mag;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_lut_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_trig_lut_unit
// Description : Self-checking bench for trig_lut_unit, sine and cosine builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_lut_unit;

    localparam real c_pi = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s, start_c;
    logic [8:0]  value_s, value_c;
    logic [31:0] amp_s, amp_c;
    logic        done_s, done_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    trig_lut_unit #(.IS_COSINE(0)) dut_sin (
        .clk_in(clk), .rst_in(rst), .start(start_s), .value(value_s),
        .amp_out(amp_s), .done(done_s)
    );

    trig_lut_unit #(.IS_COSINE(1)) dut_cos (
        .clk_in(clk), .rst_in(rst), .start(start_c), .value(value_c),
        .amp_out(amp_c), .done(done_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: round-half-away-from-zero of sin/cos(v deg) * 65536
    function automatic logic [31:0] ref_val(input bit is_cos, input int v);
        real r, x;
        int  n;
        r = real'(v % 360) * c_pi / 180.0;
        x = (is_cos ? $cos(r) : $sin(r)) * 65536.0;
        if (x >= 0.0) n = $rtoi($floor(x + 0.5));
        else          n = -$rtoi($floor(-x + 0.5));
        return 32'(n);
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [8:0] v);
        if (sel) begin start_c = st; value_c = v; end
        else     begin start_s = st; value_s = v; end
    endtask

    // One request: chg alters value after sampling, drop releases start mid-calc
    task automatic request(input bit sel, input logic [8:0] v, input logic [31:0] exp,
                           input string tag, input int hold, input bit chg, input bit drop);
        int k;
        logic [31:0] e;
        logic [8:0]  cur_v;
        exp_q.push_back(exp);
        @(negedge clk);
        drive(sel, 1'b1, v);
        cur_v = v;
        @(posedge clk);
        k = 0;
        while (k < 12) begin
            @(posedge clk);
            #1;
            k++;
            if (chg && k == 1) begin cur_v = v + 9'd47; drive(sel, 1'b1, cur_v); end
            if (drop && k == 2) drive(sel, 1'b0, cur_v);
            if (sel ? done_c : done_s) break;
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(k), 32'd5);
        check(tag, sel ? amp_c : amp_s, e);
        if (!drop) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check({tag, "_done_held"}, {31'd0, sel ? done_c : done_s}, 32'd1);
                check({tag, "_amp_held"}, sel ? amp_c : amp_s, e);
            end
            drive(sel, 1'b0, cur_v);
        end
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, {31'd0, sel ? done_c : done_s}, 32'd0);
        check({tag, "_amp_keep"}, sel ? amp_c : amp_s, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_s = 1'b0; start_c = 1'b0;
        value_s = 9'd0; value_c = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_amp_s",  amp_s, 32'd0);
        check("rst_done_s", {31'd0, done_s}, 32'd0);
        check("rst_amp_c",  amp_c, 32'd0);
        check("rst_done_c", {31'd0, done_c}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        request(0, 9'd30,  32'h0000_8000, "sin30",   3, 0, 0);
        request(1, 9'd0,   32'h0001_0000, "cos0",    2, 0, 0);
        request(1, 9'd180, 32'hFFFF_0000, "cos180",  1, 0, 0);
        request(0, 9'd270, 32'hFFFF_0000, "sin270",  1, 0, 0);
        request(0, 9'd390, 32'h0000_8000, "sin390",  0, 0, 0);
        request(1, 9'd60,  32'h0000_8000, "cos60",   0, 0, 0);
        request(0, 9'd45,  32'h0000_B505, "sin45",   0, 0, 0);
        request(0, 9'd180, 32'h0000_0000, "sin180",  0, 0, 0);
        request(1, 9'd90,  32'h0000_0000, "cos90",   0, 0, 0);
        request(1, 9'd270, 32'h0000_0000, "cos270",  0, 0, 0);
        request(0, 9'd210, 32'hFFFF_8000, "sin210",  0, 0, 0);
        request(0, 9'd30,  32'h0000_8000, "sin_chg", 0, 1, 0);
        request(1, 9'd240, 32'hFFFF_8000, "cos_chg", 0, 1, 0);
        request(1, 9'd60,  32'h0000_8000, "cos_drop", 0, 0, 1);

        // Reset two cycles into a calculation aborts it
        @(negedge clk);
        start_s = 1'b1; value_s = 9'd210;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_done", {31'd0, done_s}, 32'd0);
        check("midrst_amp_s", amp_s, 32'd0);
        check("midrst_amp_c", amp_c, 32'd0);
        @(negedge clk);
        rst = 1'b0; start_s = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_done", {31'd0, done_s}, 32'd0);
        check("abort_amp",  amp_s, 32'd0);
        request(0, 9'd60, 32'h0000_DDB4, "after_rst", 1, 0, 0);

        for (int v = 0; v < 512; v++)
            request(0, 9'(v), ref_val(0, v), $sformatf("sweep_sin%0d", v), 0, 0, 0);
        for (int v = 0; v < 512; v++)
            request(1, 9'(v), ref_val(1, v), $sformatf("sweep_cos%0d", v), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
